// File: rtl/fp16_norm_round.sv
// FP16 adder back end: normalize, round to nearest-even and pack, as a 2-stage valid/ready pipe.
// Define NORM_SUBNORMAL_EN for gradual underflow; the default build flushes tiny results to zero.
module fp16_norm_round #(
  parameter int EXP_W  = 6,
  parameter int MANT_W = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sign,
  input  logic [EXP_W-1:0]  in_exp,
  input  logic              in_carry,
  input  logic [MANT_W-1:0] in_mant,
  input  logic [2:0]        in_grs,
  input  logic [3:0]        in_lzc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [15:0]       out_result,
  output logic [3:0]        out_flags
);
  localparam int VW = MANT_W + 3;
  localparam int XW = EXP_W + 1;
  localparam logic [XW:0] EXP_INF = (XW+1)'(31);

  logic              s1_valid_reg;
  logic              s1_sign_reg;
  logic [XW-1:0]     s1_exp_reg, s1_exp_next;
  logic [MANT_W-1:0] s1_mant_reg, s1_mant_next;
  logic [2:0]        s1_grs_reg, s1_grs_next;
  logic              s1_tiny_reg, s1_tiny_next;

  logic              s1_adv, s1_load, tiny;
  logic [3:0]        sh;
  logic [VW-1:0]     shv [0:4];

  assign s1_adv   = !out_valid || out_ready;
  assign in_ready = !s1_valid_reg || s1_adv;
  assign s1_load  = in_valid && in_ready;
  assign tiny     = (in_exp <= EXP_W'(in_lzc));

`ifdef NORM_SUBNORMAL_EN
  // Tiny results stop shifting at exponent 1; the packed field then reads 0 (subnormal).
  assign sh = !tiny ? in_lzc : (in_exp == '0) ? 4'd0 : 4'(in_exp - EXP_W'(1));
`else
  assign sh = in_lzc;
`endif

  assign shv[0] = {in_mant, in_grs};
  for (genvar gi = 0; gi < 4; gi++) begin : g_shift
    assign shv[gi+1] = sh[gi] ? (shv[gi] << (1 << gi)) : shv[gi];
  end

  always_comb begin
    s1_mant_next = shv[4][VW-1:3];
    s1_grs_next  = shv[4][2:0];
    s1_exp_next  = XW'(in_exp) - XW'(sh);
    s1_tiny_next = 1'b0;
    if (in_carry) begin
      s1_mant_next = {1'b1, in_mant[MANT_W-1:1]};
      s1_grs_next  = {in_mant[0], in_grs[2], in_grs[1] | in_grs[0]};
      s1_exp_next  = XW'(in_exp) + XW'(1);
    end else if (in_lzc == 4'(MANT_W) && in_grs == 3'b000) begin
      s1_mant_next = '0;
      s1_grs_next  = '0;
      s1_exp_next  = '0;
    end else if (tiny) begin
      s1_tiny_next = 1'b1;
`ifdef NORM_SUBNORMAL_EN
      s1_exp_next  = '0;
`else
      s1_mant_next = '0;
      s1_grs_next  = '0;
      s1_exp_next  = '0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (s1_load) begin
      s1_sign_reg <= in_sign;
      s1_exp_reg  <= s1_exp_next;
      s1_mant_reg <= s1_mant_next;
      s1_grs_reg  <= s1_grs_next;
      s1_tiny_reg <= s1_tiny_next;
    end
  end

  logic              round_up, inexact, ovf, uf, zero;
  logic [MANT_W:0]   sum;
  logic [MANT_W-1:0] mant_r;
  logic [XW:0]       exp_r;
  logic [15:0]       result_next;
  logic [3:0]        flags_next;

  always_comb begin
    round_up = s1_grs_reg[2] & (s1_grs_reg[1] | s1_grs_reg[0] | s1_mant_reg[0]);
    sum      = {1'b0, s1_mant_reg} + {{MANT_W{1'b0}}, round_up};
    mant_r   = sum[MANT_W] ? sum[MANT_W:1] : sum[MANT_W-1:0];
    exp_r    = {1'b0, s1_exp_reg} + {{XW{1'b0}}, sum[MANT_W]};
    if (exp_r == '0 && mant_r[MANT_W-1])
      exp_r = (XW+1)'(1);
    inexact  = |s1_grs_reg;
    ovf      = (exp_r >= EXP_INF);
`ifdef NORM_SUBNORMAL_EN
    uf       = s1_tiny_reg && exp_r == '0 && inexact;
`else
    uf       = s1_tiny_reg;
`endif
    if (ovf) begin
      result_next = {s1_sign_reg, 5'h1F, 10'h000};
      zero        = 1'b0;
    end else begin
      result_next = {s1_sign_reg, exp_r[4:0], mant_r[MANT_W-2:0]};
      zero        = (exp_r == '0) && (mant_r[MANT_W-2:0] == '0);
    end
    flags_next = {ovf, uf, inexact | ovf, zero};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_reg <= 1'b0;
      out_valid    <= 1'b0;
      out_result   <= '0;
      out_flags    <= '0;
    end else begin
      if (in_ready)
        s1_valid_reg <= in_valid;
      if (s1_adv) begin
        out_valid <= s1_valid_reg;
        if (s1_valid_reg) begin
          out_result <= result_next;
          out_flags  <= flags_next;
        end
      end
    end
  end
endmodule

// File: tb/tb_fp16_norm_round.sv
// Bench for fp16_norm_round: directed vectors, backpressure, mid-stream reset and random traffic
// checked against a value-based round-to-nearest-even model.
module tb_fp16_norm_round;
  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, in_sign, in_carry, out_valid, out_ready;
  logic [5:0]  in_exp;
  logic [10:0] in_mant;
  logic [2:0]  in_grs;
  logic [3:0]  in_lzc, out_flags;
  logic [15:0] out_result;

  fp16_norm_round dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_exp(in_exp), .in_carry(in_carry), .in_mant(in_mant),
    .in_grs(in_grs), .in_lzc(in_lzc), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_flags(out_flags)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sign;
    logic [5:0]  e;
    logic        carry;
    logic [10:0] mant;
    logic [2:0]  grs;
    logic [3:0]  lzc;
    logic [19:0] expv;
  } beat_t;

  beat_t       stim_q[$];
  logic [19:0] exp_q[$];
  int          total = 0, bad = 0, naccept = 0, ndrain = 0;
  logic        held_valid = 1'b0;
  logic [19:0] held_val = '0;

  function automatic logic [3:0] lzc_of(input logic [10:0] m);
    for (int i = 10; i >= 0; i--) if (m[i]) return 4'(10 - i);
    return 4'd11;
  endfunction

  // Treats {carry, mant, g, r, s} as an exact integer, finds its MSB and rounds by remainder vs. half.
  function automatic logic [19:0] model(input logic sign, input int e_in, input logic carry,
                                        input logic [10:0] mant, input logic [2:0] grs);
    int   n, p, e, d, kept, rem, half;
    logic inx, uf, rup;
    n = 0;
    n[14:0] = {carry, mant, grs};
    if (n == 0) return {4'b0001, sign, 15'd0};
    p = 0;
    for (int i = 0; i < 15; i++) if (n[i]) p = i;
    e = e_in + p - 13;
    d = p - 10;
    if (e <= 0) begin
`ifdef NORM_SUBNORMAL_EN
      d = 4 - e_in;
      e = 0;
`else
      return {4'b0101, sign, 15'd0};
`endif
    end
    if (d > 0) begin
      kept = n >> d;
      rem  = n - (kept << d);
      half = 1 << (d - 1);
      rup  = (rem > half) || (rem == half && kept[0]);
      inx  = (rem != 0);
    end else begin
      kept = n << (-d);
      rup  = 1'b0;
      inx  = 1'b0;
    end
    kept = kept + int'(rup);
    if (kept == 'h800) begin
      kept = 'h400;
      e = e + 1;
    end
    if (e == 0 && kept >= 'h400) e = 1;
    if (e >= 31) return {4'b1010, sign, 5'h1F, 10'd0};
    uf = 1'b0;
`ifdef NORM_SUBNORMAL_EN
    uf = (e == 0) && inx;
`endif
    return {1'b0, uf, inx, (e == 0 && kept[9:0] == 10'd0), sign, e[4:0], kept[9:0]};
  endfunction

  function automatic beat_t rand_beat();
    beat_t b;
    b.sign  = 1'($urandom);
    b.e     = ($urandom_range(0, 2) == 0) ? 6'($urandom_range(1, 12)) : 6'($urandom_range(1, 40));
    b.carry = ($urandom_range(0, 4) == 0);
    b.mant  = 11'($urandom) >> $urandom_range(0, 11);
    b.grs   = 3'($urandom);
    if (!b.carry && b.mant == '0 && b.grs != '0) b.grs[2] = 1'b1;
    b.lzc   = lzc_of(b.mant);
    b.expv  = model(b.sign, int'(b.e), b.carry, b.mant, b.grs);
    return b;
  endfunction

  task automatic push_dir(input logic s, input logic [5:0] e, input logic c, input logic [10:0] m,
                          input logic [2:0] g, input logic [19:0] expv);
    beat_t b;
    b.sign = s; b.e = e; b.carry = c; b.mant = m; b.grs = g; b.lzc = lzc_of(m); b.expv = expv;
    stim_q.push_back(b);
  endtask

  task automatic chk(input string tag, input logic [19:0] obs, input logic [19:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // One clock: drive at the falling edge, then sample both handshakes just before the rising edge.
  task automatic step(input logic ordy, input logic ven);
    logic [19:0] e;
    @(negedge clk);
    out_ready = ordy;
    if (ven && stim_q.size() > 0) begin
      in_sign = stim_q[0].sign; in_exp = stim_q[0].e; in_carry = stim_q[0].carry;
      in_mant = stim_q[0].mant; in_grs = stim_q[0].grs; in_lzc = stim_q[0].lzc;
      in_valid = 1'b1;
    end else begin
      in_valid = 1'b0;
    end
    #1;
    if (held_valid) chk("hold_stable", {out_valid ? 4'h0 : 4'hF, out_flags, out_result}, {4'h0, held_val});
    held_valid = out_valid && !out_ready;
    held_val   = {out_flags, out_result};
    if (out_valid && out_ready) begin
      ndrain++;
      $display("out %0d: result=%h flags=%b", ndrain, out_result, out_flags);
      total++;
      assert (exp_q.size() != 0) else begin
        bad++;
        $error("FAIL spurious_out: observed=%h expected=none", {out_flags, out_result});
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("stream_result", {out_flags, out_result}, e);
      end
    end
    if (in_valid && in_ready) begin
      naccept++;
      exp_q.push_back(stim_q[0].expv);
      void'(stim_q.pop_front());
    end
  endtask

  task automatic run_until_empty(input string tag, input int budget, input bit rnd);
    int k = 0;
    while ((stim_q.size() > 0 || exp_q.size() > 0) && k < budget) begin
      if (rnd) step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 4) != 0));
      else     step(1'b1, 1'b1);
      k++;
    end
    chk(tag, 20'(stim_q.size() + exp_q.size()), 20'd0);
  endtask

  initial begin
    int base_acc, base_drn;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_sign = 1'b0; in_exp = '0;
    in_carry = 1'b0; in_mant = '0; in_grs = '0; in_lzc = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", {19'd0, in_ready}, 20'd1);
    chk("rst_out_valid", {19'd0, out_valid}, 20'd0);
    chk("rst_out", {out_flags, out_result}, 20'h0_0000);

    // Latency: accepted beat appears exactly two cycles later.
    push_dir(1'b0, 6'd15, 1'b0, 11'h400, 3'b000, 20'h0_3C00);
    step(1'b1, 1'b1);
    chk("lat_accept", 20'(naccept), 20'd1);
    step(1'b1, 1'b1);
    chk("lat_cycle1_valid", {19'd0, out_valid}, 20'd0);
    step(1'b1, 1'b1);
    chk("lat_cycle2_valid", {19'd0, out_valid}, 20'd1);
    step(1'b1, 1'b1);

    push_dir(1'b0, 6'd15, 1'b1, 11'h000, 3'b000, 20'h0_4000);
    push_dir(1'b0, 6'd15, 1'b0, 11'h001, 3'b000, 20'h0_1400);
    push_dir(1'b1, 6'd15, 1'b0, 11'h000, 3'b000, 20'h1_8000);
    push_dir(1'b0, 6'd15, 1'b0, 11'h401, 3'b100, 20'h2_3C02);
    push_dir(1'b0, 6'd15, 1'b0, 11'h400, 3'b100, 20'h2_3C00);
    push_dir(1'b0, 6'd15, 1'b0, 11'h400, 3'b101, 20'h2_3C01);
    push_dir(1'b0, 6'd30, 1'b0, 11'h7FF, 3'b110, 20'hA_7C00);
    push_dir(1'b0, 6'd2,  1'b0, 11'h3FF, 3'b000, 20'h0_07FE);
`ifdef NORM_SUBNORMAL_EN
    push_dir(1'b0, 6'd3,  1'b0, 11'h001, 3'b000, 20'h0_0004);
    push_dir(1'b0, 6'd1,  1'b0, 11'h3FF, 3'b100, 20'h2_0400);
`else
    push_dir(1'b0, 6'd3,  1'b0, 11'h001, 3'b000, 20'h5_0000);
    push_dir(1'b0, 6'd1,  1'b0, 11'h3FF, 3'b100, 20'h5_0000);
`endif
    run_until_empty("directed_drain", 60, 1'b0);

    // Backpressure: consumer stalls while four beats are offered back to back.
    base_acc = naccept;
    base_drn = ndrain;
    for (int i = 0; i < 4; i++) stim_q.push_back(rand_beat());
    repeat (4) step(1'b0, 1'b1);
    chk("bp_accepts", 20'(naccept - base_acc), 20'd2);
    chk("bp_in_ready", {19'd0, in_ready}, 20'd0);
    run_until_empty("bp_drain", 40, 1'b0);
    repeat (2) step(1'b1, 1'b1);
    chk("bp_drained", 20'(ndrain - base_drn), 20'd4);

    // Reset pulse with the pipe full empties it.
    for (int i = 0; i < 4; i++) stim_q.push_back(rand_beat());
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    stim_q.delete();
    exp_q.delete();
    held_valid = 1'b0;
    #1;
    chk("midrst_out_valid", {19'd0, out_valid}, 20'd0);
    chk("midrst_in_ready", {19'd0, in_ready}, 20'd1);
    base_drn = ndrain;
    repeat (4) step(1'b1, 1'b1);
    chk("midrst_no_output", 20'(ndrain - base_drn), 20'd0);

    // Random traffic with random bubbles and stalls.
    for (int i = 0; i < 200; i++) stim_q.push_back(rand_beat());
    run_until_empty("random_drain", 4000, 1'b1);
    repeat (3) step(1'b1, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
